shift_unit_pipe: RTL
====================

# shift_unit_pipe

Parametrised, pipelined shift unit that generalises the ALU's fixed 8-bit logical right shifter.
- Supports any power-of-two width and four shift modes: logical right, logical left, arithmetic right, rotate right.
- Produces carry-out and zero flags alongside the result.
- Sits in the ALU datapath behind the operand select, using a valid/ready handshake on both sides so it can stall with the writeback stage.

## Interface
Parameters:
- WIDTH, 8, data width; power of two, 8 to 64.
- SHW, $clog2(WIDTH)+1, derived shift-amount width (not overridden); allows amounts 0..2·WIDTH−1.

Ports:
- clk_i  input  1  single clock; all state on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  request valid.
- ready_o  output  1  unit accepts a request this cycle.
- op_i  input  2  mode: 00 LSR, 01 LSL, 10 ASR, 11 ROR.
- a  input  WIDTH  operand.
- b  input  SHW  shift amount, unsigned.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.
- c_o  output  WIDTH  shifted result.
- carry_o  output  1  last bit shifted out.
- zero_o  output  1  c_o == 0.

## Operation
- Transfer in on valid_i && ready_o; transfer out on valid_o && ready_i.
- Global advance: adv = !valid_o || ready_i; ready_o = adv.
  - All pipeline registers, including each stage's valid bit, load only when adv.
  - On stall everything holds.
  - Internal bubbles are not compacted.
- Decomposition: log2(WIDTH) binary stages, where stage k shifts by 2^k if b[k]. Amount bit b[SHW−1] (b ≥ WIDTH) is handled at the input:
  - LSR/LSL: result 0.
  - ASR: result all sign bits.
  - ROR: amount taken mod WIDTH.
- Amount 0: c_o = a, carry_o = 0 in all modes.
- carry_o:
  - LSR: a[b−1] for 1 ≤ b ≤ WIDTH, else 0.
  - LSL: a[WIDTH−b] for 1 ≤ b ≤ WIDTH, else 0.
  - ASR: a[b−1] for 1 ≤ b ≤ WIDTH; a[WIDTH−1] for b > WIDTH.
  - ROR: c_o[WIDTH−1] when (b mod WIDTH) ≠ 0, else 0.
- zero_o is computed from the final result and registered with it.
- Results leave in request order; no reordering, no drops except on reset.

## Timing
- Reset values: valid_o=0, c_o=0, carry_o=0, zero_o=0, all internal valid bits 0. ready_o=1 the cycle after reset.
- Reset mid-operation flushes all in-flight requests with no output. A request presented while rst_i=1 is ignored.
- Latency from accept to valid_o:
  - log2(WIDTH) cycles with SHIFT_UNIT_PIPELINE_EN defined (3 for WIDTH=8).
  - 1 cycle without it.
- Throughput is 1 per cycle while ready_i=1.
- valid_o=1 && ready_i=0: c_o, carry_o, zero_o and valid_o hold stable until taken. ready_o=0 for those cycles.
- Simultaneous output take and input accept in the same cycle is legal and loses no data.

## Configuration
- SHIFT_UNIT_PIPELINE_EN defined: one register stage after each binary shift stage, giving log2(WIDTH) stages, each with its own valid bit.
- Not defined: all shift stages are combinational into a single output register. The same handshake applies with 1-cycle latency.
- Results, flags and ordering are identical in both builds; only latency differs.

## Test plan
- WIDTH=8, a=8'hB5, b=3, all four ops back-to-back with ready_i=1 ->
  - LSR: c_o=8'h16, carry=1.
  - LSL: c_o=8'hA8, carry=1.
  - ASR: c_o=8'hF6, carry=1.
  - ROR: c_o=8'hB6, carry=1.
  - Results arrive on 4 consecutive cycles at the configured latency.
- a=8'hB5, b=9 ->
  - LSR: c_o=0, carry=0, zero=1.
  - ASR: c_o=8'hFF, carry=1.
  - ROR: c_o=8'hDA.
  - LSL: c_o=0, zero=1.
- a=8'h81, b=8 ->
  - LSR: c_o=0, carry=1.
  - LSL: c_o=0, carry=1.
  - ROR: c_o=8'h81, carry=0.
  - b=0 in any mode: c_o=8'h81, carry=0, zero=0.
- Stream 6 requests, hold ready_i=0 for 4 cycles mid-stream -> ready_o=0 while valid_o=1; held outputs stable; all 6 results delivered in order, none duplicated.
- Reset asserted one cycle after accepting 2 requests -> no valid_o pulse follows; valid_o=0, c_o=0, flags 0; next request after reset completes normally.
- Randomised ops/amounts on WIDTH=32 in both macro builds -> results match the reference model; latencies are 5 and 1 respectively.

Source files
------------

// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: parametrised shift unit (LSR, LSL, ASR, ROR) with carry
// and zero flags, valid/ready on both sides and a single global advance.
// The shift is decomposed into log2(WIDTH) binary stages; stage k shifts by
// 2^k when its amount bit is set. Amounts >= WIDTH are resolved up front.
// Build option: define SHIFT_UNIT_PIPELINE_EN to register after every binary
// stage (latency log2(WIDTH)); otherwise all stages feed one output register
// combinationally (latency 1). Results and flags are identical in both builds.
module shift_unit_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   b,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] c_o,
  output logic             carry_o,
  output logic             zero_o
);

  localparam int NS = SHW - 1;

  localparam logic [1:0] OP_LSR = 2'b00;
  localparam logic [1:0] OP_LSL = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Work item carried through the binary stages: partial result, the last
  // bit shifted out so far, the mode and the amount bits still to apply.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic [1:0]       op;
    logic [NS-1:0]    amt;
  } stg_t;

  // Resolve the amount MSB (b >= WIDTH) before the binary stages. LSR/LSL
  // flush to zero, ASR fills with the sign, ROR simply drops the MSB (mod).
  // For b == WIDTH exactly, the last bit out is the far end of the operand.
  function automatic stg_t pre_stage(input logic [1:0]       op,
                                     input logic [WIDTH-1:0] av,
                                     input logic [SHW-1:0]   bv);
    stg_t r;
    r.data  = av;
    r.carry = 1'b0;
    r.op    = op;
    r.amt   = bv[NS-1:0];
    if (bv[SHW-1] && (op != OP_ROR)) begin
      r.amt = '0;
      case (op)
        OP_LSR: begin
          r.data  = '0;
          r.carry = (bv[NS-1:0] == '0) ? av[WIDTH-1] : 1'b0;
        end
        OP_LSL: begin
          r.data  = '0;
          r.carry = (bv[NS-1:0] == '0) ? av[0] : 1'b0;
        end
        default: begin
          r.data  = {WIDTH{av[WIDTH-1]}};
          r.carry = av[WIDTH-1];
        end
      endcase
    end
    return r;
  endfunction

  // One binary stage: shift by 2^k when amount bit k is set. The carry is
  // overwritten by the last bit leaving this stage, so after all stages it
  // holds the last bit shifted out of the whole operation. For ROR that bit
  // is the one landing in the MSB, matching c_o[WIDTH-1].
  function automatic stg_t shift_stage(input stg_t s, input int k);
    stg_t r;
    int   sh;
    r  = s;
    sh = 1 << k;
    if (((s.amt >> k) & NS'(1)) != '0) begin
      case (s.op)
        OP_LSR: begin
          r.data  = s.data >> sh;
          r.carry = |(s.data & (WIDTH'(1) << (sh - 1)));
        end
        OP_LSL: begin
          r.data  = s.data << sh;
          r.carry = |(s.data & (WIDTH'(1) << (WIDTH - sh)));
        end
        OP_ASR: begin
          r.data  = $signed(s.data) >>> sh;
          r.carry = |(s.data & (WIDTH'(1) << (sh - 1)));
        end
        default: begin
          r.data  = (s.data >> sh) | (s.data << (WIDTH - sh));
          r.carry = |(s.data & (WIDTH'(1) << (sh - 1)));
        end
      endcase
    end
    return r;
  endfunction

  logic             adv;
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] c_d, c_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  stg_t             res;
  logic             unused_ok;

  // Whole pipe moves together; a held output freezes every stage behind it.
  assign adv     = !valid_q || ready_i;
  assign ready_o = adv;
  assign valid_o = valid_q;
  assign c_o     = c_q;
  assign carry_o = carry_q;
  assign zero_o  = zero_q;

  // Mode and leftover amount bits are consumed by the last stage only.
  assign unused_ok = ^{res.op, res.amt};

`ifdef SHIFT_UNIT_PIPELINE_EN
  localparam int NR = NS - 1;

  stg_t          stg_d [NR];
  stg_t          stg_q [NR];
  logic [NR-1:0] vld_d, vld_q;

  // Stage 0 works on the request; stage k works on register k-1; the final
  // stage feeds the output register directly.
  always_comb begin
    stg_d[0] = shift_stage(pre_stage(op_i, a, b), 0);
    for (int k = 1; k < NR; k++) begin
      stg_d[k] = shift_stage(stg_q[k-1], k);
    end
    res      = shift_stage(stg_q[NR-1], NS - 1);
    vld_d[0] = valid_i;
    for (int k = 1; k < NR; k++) begin
      vld_d[k] = vld_q[k-1];
    end
    valid_d = vld_q[NR-1];
    c_d     = res.data;
    carry_d = res.carry;
    zero_d  = (res.data == '0);
  end

  // Intermediate stage data: loads on advance, no reset needed.
  always_ff @(posedge clk_i) begin
    if (adv) begin
      stg_q <= stg_d;
    end
  end

  // Intermediate stage valid bits: cleared by reset to flush in-flight work.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end
`else
  // All binary stages in one combinational chain into the output register.
  always_comb begin
    res = pre_stage(op_i, a, b);
    for (int k = 0; k < NS; k++) begin
      res = shift_stage(res, k);
    end
    valid_d = valid_i;
    c_d     = res.data;
    carry_d = res.carry;
    zero_d  = (res.data == '0);
  end
`endif

  // Output register: result and flags held stable while downstream stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      c_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv) begin
      valid_q <= valid_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

endmodule
